// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and data_mem_responder.
// The master drives requests and takes responses. The slave (the memory
// responder) drives request-ready and the response fields.
interface data_mem_responder_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [1:0]  i_req_mask_type;
    logic        i_req_ext_type;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata,
               i_req_mask_type, i_req_ext_type, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata,
               i_req_mask_type, i_req_ext_type, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory with a request/response handshake.
// It handles byte, half and word loads and stores, with sign or zero
// extension on loads and a programmable number of wait states.
// The storage is read or written exactly once per request, on the edge
// that enters RESP. The response registers are loaded on the next edge.
// Optional macro DMEM_RESPONDER_ERR_EN: fault on misaligned or
// out-of-range accesses and on mask 11. When the macro is not defined,
// addresses wrap, accesses are aligned down and mask 11 acts as word.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

    // Returns 1 when a request must fault.
    function automatic logic req_fault(input logic [31:0] a, input logic [1:0] m);
`ifdef DMEM_RESPONDER_ERR_EN
        logic f;
        case (m)
            2'b00:   f = 1'b0;
            2'b01:   f = a[0];
            2'b10:   f = |a[1:0];
            default: f = 1'b1;
        endcase
        if ((a >> (AW + 2)) != 32'd0) f = 1'b1;
        else                          f = f;
        req_fault = f;
`else
        req_fault = (^{a, m}) & 1'b0;
`endif
    endfunction

    // Selects the byte lanes that a store writes.
    function automatic logic [3:0] lane_en(input logic [1:0] a, input logic [1:0] m);
        case (m)
            2'b00:   lane_en = 4'b0001 << a;
            2'b01:   lane_en = a[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    // Copies the LSB-aligned store data into every lane it can occupy.
    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] m);
        case (m)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // Extracts the addressed byte or half from a word and extends it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] m, input logic z);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (m)
            2'b00:   load_ext = z ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = z ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d, ext_q, ext_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, raw_q, raw_d;
    logic [1:0]  mask_q, mask_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] mem [DEPTH_WORDS];

    logic          req_ready_s, accept_s, access_s, mem_wr_s;
    logic          acc_we_s;
    logic [31:0]   acc_addr_s, acc_wdata_s;
    logic [1:0]    acc_mask_s;
    logic [AW-1:0] idx_s;
    logic [3:0]    wr_be_s;
    logic [31:0]   wr_data_s;

    assign req_ready_s = i_rst_n & (state_q == S_IDLE);
    assign accept_s    = bus.i_req_valid & req_ready_s;

    // Select the request fields for the access: the live bus in IDLE, otherwise the latched copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we_s    = bus.i_req_we;
            acc_addr_s  = bus.i_req_addr;
            acc_wdata_s = bus.i_req_wdata;
            acc_mask_s  = bus.i_req_mask_type;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
            acc_mask_s  = mask_q;
        end
    end

    // Detect the edge that enters RESP, where the single storage access happens.
    always_comb begin
        case (state_q)
            S_IDLE:  access_s = accept_s && (WAIT_CYCLES == 0);
            S_WAIT:  access_s = (cnt_q == 4'd0);
            default: access_s = 1'b0;
        endcase
    end

    assign idx_s     = acc_addr_s[AW+1:2];
    assign mem_wr_s  = access_s & acc_we_s & ~req_fault(acc_addr_s, acc_mask_s);
    assign wr_be_s   = lane_en(acc_addr_s[1:0], acc_mask_s);
    assign wr_data_s = lane_data(acc_wdata_s, acc_mask_s);

    // Next-state logic for the request FSM and the response registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        ext_d       = ext_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        raw_d       = access_s ? mem[idx_s] : raw_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    we_d    = bus.i_req_we;
                    addr_d  = bus.i_req_addr;
                    wdata_d = bus.i_req_wdata;
                    mask_d  = bus.i_req_mask_type;
                    ext_d   = bus.i_req_ext_type;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    if (req_fault(addr_q, mask_q)) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? 32'd0 : load_ext(raw_q, addr_q[1:0], mask_q, ext_q);
                    end
                end else if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control, request latch and response registers; reset drops any in-flight request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mask_q      <= 2'b00;
            ext_q       <= 1'b0;
            raw_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            ext_q       <= ext_d;
            raw_q       <= raw_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane store commit; storage contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_s[i]) mem[idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

    assign bus.o_req_ready = req_ready_s;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with the default parameters
// (DEPTH_WORDS = 1024, WAIT_CYCLES = 1). Expectations that depend on
// DMEM_RESPONDER_ERR_EN follow the same macro.
module tb_data_mem_responder;
    localparam int WAIT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; hold = number of cycles that i_rsp_ready stays low after o_rsp_valid rises.
    task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] m, input logic z, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, {31'd0, bus.o_req_ready}, 32'd1);
        bus.i_req_valid     = 1'b1;
        bus.i_req_we        = we;
        bus.i_req_addr      = a;
        bus.i_req_wdata     = wd;
        bus.i_req_mask_type = m;
        bus.i_req_ext_type  = z;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, bus.o_req_ready}, 32'd0);
        lat = 0;
        while (bus.o_rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
        chk({tag, "_rdata"}, bus.o_rsp_rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, bus.o_rsp_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, {31'd0, bus.o_rsp_valid}, 32'd1);
            chk({tag, "_hold_d"}, bus.o_rsp_rdata, exp_rd);
            chk({tag, "_hold_r"}, {31'd0, bus.o_req_ready}, 32'd0);
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        chk({tag, "_done_v"}, {31'd0, bus.o_rsp_valid}, 32'd0);
        chk({tag, "_done_r"}, {31'd0, bus.o_req_ready}, 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_valid     = 1'b0;
        bus.i_req_we        = 1'b0;
        bus.i_req_addr      = 32'd0;
        bus.i_req_wdata     = 32'd0;
        bus.i_req_mask_type = 2'b00;
        bus.i_req_ext_type  = 1'b0;
        bus.i_rsp_ready     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.o_req_ready}, 32'd0);
        chk("rst_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.o_rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", {31'd0, bus.o_req_ready}, 32'd1);

        // Word store and load back
        xact("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'd0, 1'b0, 0);
        xact("ld_w10", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);

        // Byte store into lane 3, then signed, unsigned and word loads
        xact("st_b13", 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'd0, 1'b0, 0);
        xact("ld_b13s", 1'b0, 32'h13, 32'd0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 0);
        xact("ld_b13u", 1'b0, 32'h13, 32'd0, 2'b00, 1'b1, 32'h00000080, 1'b0, 0);
        xact("ld_w10b", 1'b0, 32'h10, 32'd0, 2'b10, 1'b1, 32'h80ADBEEF, 1'b0, 0);

        // Response held off for 5 cycles
        xact("ld_hold", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 5);

        // Half loads from both halves
        xact("ld_h12s", 1'b0, 32'h12, 32'd0, 2'b01, 1'b0, 32'hFFFF80AD, 1'b0, 0);
        xact("ld_h12u", 1'b0, 32'h12, 32'd0, 2'b01, 1'b1, 32'h000080AD, 1'b0, 0);
        xact("ld_h10s", 1'b0, 32'h10, 32'd0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, 0);

        // Misaligned half store, out-of-range address, reserved mask
        xact("st_w20", 1'b1, 32'h20, 32'h55667788, 2'b10, 1'b0, 32'd0, 1'b0, 0);
`ifdef DMEM_RESPONDER_ERR_EN
        xact("st_h21", 1'b1, 32'h21, 32'h00001234, 2'b01, 1'b0, 32'd0, 1'b1, 0);
        xact("ld_w20", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h55667788, 1'b0, 0);
        xact("ld_wrap", 1'b0, 32'h1010, 32'd0, 2'b10, 1'b0, 32'd0, 1'b1, 0);
        xact("ld_m11", 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 32'd0, 1'b1, 0);
`else
        xact("st_h21", 1'b1, 32'h21, 32'h00001234, 2'b01, 1'b0, 32'd0, 1'b0, 0);
        xact("ld_w20", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h55661234, 1'b0, 0);
        xact("ld_wrap", 1'b0, 32'h1010, 32'd0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 0);
        xact("ld_m11", 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 32'h80ADBEEF, 1'b0, 0);
`endif

        // Reset during the WAIT state of a store aborts the write
        xact("st_w40z", 1'b1, 32'h40, 32'h00000000, 2'b10, 1'b0, 32'd0, 1'b0, 0);
        @(negedge clk);
        bus.i_req_valid     = 1'b1;
        bus.i_req_we        = 1'b1;
        bus.i_req_addr      = 32'h40;
        bus.i_req_wdata     = 32'hCAFEF00D;
        bus.i_req_mask_type = 2'b10;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", {31'd0, bus.o_req_ready}, 32'd0);
        chk("abort_v", {31'd0, bus.o_rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_rdy", {31'd0, bus.o_req_ready}, 32'd1);
        chk("abort_rel_v", {31'd0, bus.o_rsp_valid}, 32'd0);
        xact("ld_w40", 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, 32'd0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
